// File: rtl/rst_gen_pkg.sv
// rtl/rst_gen_pkg.sv - shared types and width helpers for the board reset generator
package rst_gen_pkg;

    // Reset sequencer states: pulse reset, wait for PLL lock, running, latched fault
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        WAIT  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Depth of the two-flop synchronisers on asynchronous inputs
    localparam int SYNC_STAGES = 2;

    // Bits needed by a counter that runs 0..n-1; never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed by a counter that runs 0..n inclusive
    function automatic int sat_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rst_gen_key_debounce.sv
// rtl/rst_gen_key_debounce.sv - key synchroniser, stability debouncer and press pulse
module key_debounce
    import rst_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_key_press
);

    localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);

    logic            r_key_meta;
    logic            r_key_s;
    logic            r_level;
    logic [DB_W-1:0] r_cnt;
    logic            r_press;

    // Two-flop synchroniser; presets to released so reset does not fake a press
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_meta <= 1'b1;
            r_key_s    <= 1'b1;
        end else begin
            r_key_meta <= i_key_n;
            r_key_s    <= r_key_meta;
        end
    end

    // Accept a new level only after it has differed from the current one for
    // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_key_s != r_level) begin
                if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= r_key_s;
                    r_cnt   <= '0;
                    r_press <= ~r_key_s;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_key_press = r_press;

endmodule

// File: rtl/rst_gen.sv
// rtl/rst_gen.sv - board reset source with key debounce, PLL lock supervision and retry limit
module rst_gen
    import rst_gen_pkg::*;
#(
    parameter int HOLD_CYCLES     = 1024,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_RETRY       = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           key_n_i,
    input  logic                           pll_lock_i,
    output logic                           rst_n_o,
    output logic                           sys_ready_o,
    output logic                           fault_o,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o
);

    localparam int CNT_MAX = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_W   = cnt_w(CNT_MAX);
    localparam int RTY_W   = $clog2(MAX_RETRY + 1);

    logic              r_lock_meta;
    logic              r_lock_s;
    logic              w_key_press;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [RTY_W-1:0]  r_retry;
    logic              r_rst_n;
    logic              r_ready;
    logic              r_fault;

    state_t            w_next_state;
    logic [RTY_W-1:0]  w_next_retry;
    logic              w_fail;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_key_n     (key_n_i),
        .o_key_press (w_key_press)
    );

    // Bring the PLL lock into the board clock domain; unlocked while in reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock_i;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Next-state decision; a key press overrides every other event this cycle
    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry;
        w_fail       = 1'b0;
        if (w_key_press) begin
            w_next_state = HOLD;
            w_next_retry = '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        w_next_state = WAIT;
                    end
                end
                WAIT: begin
                    // Lock seen on the timeout cycle still counts as success
                    if (r_lock_s) begin
                        w_next_state = RUN;
                    end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        w_fail = 1'b1;
                    end
                end
                RUN: begin
                    if (!r_lock_s) begin
                        w_fail = 1'b1;
                    end
                end
                FAULT: begin
                    w_next_state = FAULT;
                end
                default: begin
                    w_next_state = HOLD;
                end
            endcase

            if (w_fail) begin
                if (r_retry == RTY_W'(MAX_RETRY - 1)) begin
                    w_next_state = FAULT;
                    w_next_retry = RTY_W'(MAX_RETRY);
                end else begin
                    w_next_state = HOLD;
                    w_next_retry = r_retry + RTY_W'(1);
                end
            end
        end
    end

    // State, shared HOLD/WAIT timer and outputs registered from the next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= HOLD;
            r_cnt   <= '0;
            r_retry <= '0;
            r_rst_n <= 1'b0;
            r_ready <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_retry <= w_next_retry;
            // A key press in HOLD re-enters HOLD, so it must restart the timer too
            if (w_key_press || (w_next_state != r_state)) begin
                r_cnt <= '0;
            end else if ((r_state == HOLD) || (r_state == WAIT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Reset is released in WAIT because the PLL can only lock out of reset
            r_rst_n <= (w_next_state == WAIT) || (w_next_state == RUN);
            r_ready <= (w_next_state == RUN);
            r_fault <= (w_next_state == FAULT);
        end
    end

    assign rst_n_o     = r_rst_n;
    assign sys_ready_o = r_ready;
    assign fault_o     = r_fault;
    assign retry_cnt_o = r_retry;

endmodule

// File: tb/tb_rst_gen.sv
// tb/tb_rst_gen.sv - directed self-checking bench for rst_gen
module tb_rst_gen;

    localparam int HOLD = 8;
    localparam int TMO  = 20;
    localparam int DEB  = 16;
    localparam int MR   = 3;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       key_n  = 1'b1;
    logic       pll_ok = 1'b0;
    logic       pll_lock;
    logic       rst_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int n;
    int bad;

    // PLL model: can only be locked while its reset is released
    assign pll_lock = rst_n & pll_ok;

    always #5 clk = ~clk;

    rst_gen #(
        .HOLD_CYCLES     (HOLD),
        .LOCK_TIMEOUT    (TMO),
        .DEBOUNCE_CYCLES (DEB),
        .MAX_RETRY       (MR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .key_n_i     (key_n),
        .pll_lock_i  (pll_lock),
        .rst_n_o     (rst_n),
        .sys_ready_o (ready),
        .fault_o     (fault),
        .retry_cnt_o (retry)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count clock edges until the selected output reaches lvl (0=rst_n,1=ready,2=fault)
    task automatic cycles_until(input int sel, input logic lvl, output int cnt);
        logic v;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            case (sel)
                0:       v = rst_n;
                1:       v = ready;
                default: v = fault;
            endcase
        end while ((v !== lvl) && (cnt < 2000));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Power-up
        pll_ok = 1'b1;
        step(5);
        check("rst_rst_n", rst_n, 0);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_retry", retry, 0);
        rst = 1'b0;
        cycles_until(0, 1'b1, n);
        check("pwr_hold_len", n, HOLD);
        cycles_until(1, 1'b1, n);
        check("pwr_ready_lat", n, 3);
        check("pwr_retry", retry, 0);
        step(5);

        // Lock loss in RUN for one cycle
        pll_ok = 1'b0;
        step(1);
        pll_ok = 1'b1;
        cycles_until(0, 1'b0, n);
        check("loss_lat", n + 1, 3);
        check("loss_ready", ready, 0);
        check("loss_retry", retry, 1);
        cycles_until(0, 1'b1, n);
        check("loss_hold_len", n, HOLD);
        cycles_until(1, 1'b1, n);
        check("loss_relock", n, 3);
        check("loss_retry_kept", retry, 1);

        // Lock timeout rounds into FAULT
        pll_ok = 1'b0;
        rst    = 1'b1;
        step(2);
        check("rst2_retry", retry, 0);
        rst = 1'b0;
        for (int r = 1; r <= 2; r++) begin
            cycles_until(0, 1'b1, n);
            check("tmo_hold_len", n, HOLD);
            cycles_until(0, 1'b0, n);
            check("tmo_wait_len", n, TMO);
            check("tmo_retry", retry, r);
            check("tmo_fault", fault, 0);
        end
        cycles_until(0, 1'b1, n);
        check("tmo3_hold_len", n, HOLD);
        cycles_until(0, 1'b0, n);
        check("tmo3_wait_len", n, TMO);
        check("fault_set", fault, 1);
        check("fault_retry", retry, 3);
        check("fault_rst_n", rst_n, 0);
        bad = 0;
        repeat (1000) begin
            step(1);
            if (fault !== 1'b1 || rst_n !== 1'b0 || retry !== 2'd3 || ready !== 1'b0) bad++;
        end
        check("fault_hold", bad, 0);

        // Bouncing key must not be accepted
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            key_n = i[0];
            repeat (5) begin
                step(1);
                if (fault !== 1'b1 || retry !== 2'd3) bad++;
            end
        end
        check("bounce_ignored", bad, 0);
        step(5);

        // Stable press clears FAULT with a single HOLD
        pll_ok = 1'b1;
        key_n  = 1'b0;
        cycles_until(2, 1'b0, n);
        check("press_lat", n, 19);
        check("press_retry", retry, 0);
        check("press_rst_n", rst_n, 0);
        cycles_until(0, 1'b1, n);
        check("press_hold_len", n, HOLD);
        cycles_until(1, 1'b1, n);
        check("press_relock", n, 3);
        key_n = 1'b1;
        step(30);
        check("press_single", ready, 1);
        check("press_retry_run", retry, 0);

        // Key press coincident with lock loss: key wins, no retry
        key_n = 1'b0;
        step(16);
        pll_ok = 1'b0;
        cycles_until(0, 1'b0, n);
        check("prio_lat", n + 16, 19);
        check("prio_retry", retry, 0);
        check("prio_ready", ready, 0);
        key_n = 1'b1;

        // Lock arriving on the WAIT timeout cycle wins
        cycles_until(0, 1'b1, n);
        check("edge_hold_len", n, HOLD);
        step(17);
        pll_ok = 1'b1;
        step(2);
        check("edge_pre_ready", ready, 0);
        check("edge_pre_rst_n", rst_n, 1);
        step(1);
        check("edge_ready", ready, 1);
        check("edge_rst_n", rst_n, 1);
        check("edge_retry", retry, 0);

        // Asynchronous reset in the middle of WAIT
        step(5);
        pll_ok = 1'b0;
        cycles_until(0, 1'b0, n);
        check("async_loss_lat", n, 3);
        check("async_pre_retry", retry, 1);
        cycles_until(0, 1'b1, n);
        check("async_hold_len", n, HOLD);
        step(10);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_n", rst_n, 0);
        check("async_ready", ready, 0);
        check("async_fault", fault, 0);
        check("async_retry", retry, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles_until(0, 1'b1, n);
        check("async_hold_after", n, HOLD);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
